// File: rtl/rip_csr_unit_if.sv
// Pipeline <-> CSR unit bundle: Zicsr request/response, trap and MRET requests, PC redirect, stall.
interface rip_csr_unit_if #(parameter int XLEN = 32);
    logic            csr_valid;
    logic [2:0]      csr_op;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            csr_rvalid;
    logic            csr_illegal;
    logic            trap_req;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_pc;
    logic            mret_req;
    logic            instret_pulse;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc,
               mret_req, instret_pulse,
        input  csr_rdata, csr_rvalid, csr_illegal, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc,
               mret_req, instret_pulse,
        output csr_rdata, csr_rvalid, csr_illegal, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/rip_csr_unit.sv
// Machine-mode CSR file + trap/MRET sequencer for the rip core.
// Optional 64-bit mcycle/minstret counters when RIP_CSR_COUNTERS_EN is defined.
module rip_csr_unit #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] HART_ID     = '0
) (
    input logic           clk,
    input logic           rst,
    rip_csr_unit_if.slave bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MHARTID  = 12'hF14;
`ifdef RIP_CSR_COUNTERS_EN
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_TRAP_SAVE, S_TRAP_JUMP, S_MRET_RESTORE, S_MRET_JUMP
    } state_t;

    state_t          state;
    logic            mie, mpie;
    logic [XLEN-1:0] mtvec, mepc, mcause, mscratch;
    logic [XLEN-1:0] trap_pc_q, trap_cause_q;
    logic [XLEN-1:0] rdata_q, redirect_pc_q;
    logic            rvalid_q, illegal_q, redirect_valid_q;
`ifdef RIP_CSR_COUNTERS_EN
    logic [63:0]     mcycle, minstret, mcycle_nxt, minstret_nxt;
`endif

    logic [XLEN-1:0] mstatus_rd, rd_val, wr_val;
    logic            rd_hit, rd_ro, wr_en, illegal, csr_fire, do_wr;

    always_comb begin
        mstatus_rd        = '0;
        mstatus_rd[12:11] = 2'b11;
        mstatus_rd[7]     = mpie;
        mstatus_rd[3]     = mie;
    end

    // Address class 11 in [11:10] is read-only in the Zicsr map.
    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        rd_ro  = (bus.csr_addr[11:10] == 2'b11);
        case (bus.csr_addr)
            A_MSTATUS:  rd_val = mstatus_rd;
            A_MTVEC:    rd_val = mtvec;
            A_MSCRATCH: rd_val = mscratch;
            A_MEPC:     rd_val = mepc;
            A_MCAUSE:   rd_val = mcause;
            A_MHARTID:  rd_val = HART_ID;
`ifdef RIP_CSR_COUNTERS_EN
            A_MCYCLE, A_CYCLE:     rd_val = XLEN'(mcycle);
            A_MINSTRET, A_INSTRET: rd_val = XLEN'(minstret);
            A_MCYCLEH, A_CYCLEH: begin
                if (XLEN == 32) rd_val = XLEN'(mcycle[63:32]);
                else            rd_hit = 1'b0;
            end
            A_MINSTRETH, A_INSTRETH: begin
                if (XLEN == 32) rd_val = XLEN'(minstret[63:32]);
                else            rd_hit = 1'b0;
            end
`endif
            default: rd_hit = 1'b0;
        endcase
    end

    always_comb begin
        case (bus.csr_op[1:0])
            2'b10:   wr_val = rd_val | bus.csr_wdata;
            2'b11:   wr_val = rd_val & ~bus.csr_wdata;
            default: wr_val = bus.csr_wdata;
        endcase
    end

    // Set/clear with a zero operand is a pure read and must not trip the RO check.
    assign wr_en    = (bus.csr_op[1:0] == 2'b01) || (bus.csr_wdata != '0);
    assign illegal  = !rd_hit || (bus.csr_op[1:0] == 2'b00) || (rd_ro && wr_en);
    assign csr_fire = (state == S_IDLE) && bus.csr_valid && !bus.trap_req && !bus.mret_req;
    assign do_wr    = csr_fire && !illegal && wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            mie              <= 1'b0;
            mpie             <= 1'b0;
            mtvec            <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mepc             <= '0;
            mcause           <= '0;
            mscratch         <= '0;
            trap_pc_q        <= '0;
            trap_cause_q     <= '0;
            rdata_q          <= '0;
            rvalid_q         <= 1'b0;
            illegal_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            rvalid_q         <= 1'b0;
            illegal_q        <= 1'b0;
            redirect_valid_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.trap_req) begin
                        trap_pc_q    <= {bus.trap_pc[XLEN-1:2], 2'b00};
                        trap_cause_q <= bus.trap_cause;
                        state        <= S_TRAP_SAVE;
                    end else if (bus.mret_req) begin
                        state <= S_MRET_RESTORE;
                    end else if (bus.csr_valid) begin
                        rvalid_q  <= 1'b1;
                        illegal_q <= illegal;
                        rdata_q   <= illegal ? '0 : rd_val;
                        if (do_wr) begin
                            case (bus.csr_addr)
                                A_MSTATUS: begin
                                    mie  <= wr_val[3];
                                    mpie <= wr_val[7];
                                end
                                A_MTVEC:    mtvec    <= {wr_val[XLEN-1:2], 2'b00};
                                A_MSCRATCH: mscratch <= wr_val;
                                A_MEPC:     mepc     <= {wr_val[XLEN-1:2], 2'b00};
                                A_MCAUSE:   mcause   <= wr_val;
                                default: ;
                            endcase
                        end
                    end
                end
                S_TRAP_SAVE: begin
                    mepc             <= trap_pc_q;
                    mcause           <= trap_cause_q;
                    mpie             <= mie;
                    mie              <= 1'b0;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= mtvec;
                    state            <= S_TRAP_JUMP;
                end
                S_MRET_RESTORE: begin
                    mie              <= mpie;
                    mpie             <= 1'b1;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= mepc;
                    state            <= S_MRET_JUMP;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RIP_CSR_COUNTERS_EN
    // A software write replaces the whole counter value for that cycle, increment dropped.
    always_comb begin
        mcycle_nxt   = mcycle + 64'd1;
        minstret_nxt = minstret + {63'd0, bus.instret_pulse};
        if (do_wr && bus.csr_addr == A_MCYCLE) begin
            mcycle_nxt              = mcycle;
            mcycle_nxt[XLEN-1:0]    = wr_val;
        end else if (do_wr && bus.csr_addr == A_MCYCLEH) begin
            mcycle_nxt              = mcycle;
            mcycle_nxt[63:32]       = wr_val[31:0];
        end
        if (do_wr && bus.csr_addr == A_MINSTRET) begin
            minstret_nxt            = minstret;
            minstret_nxt[XLEN-1:0]  = wr_val;
        end else if (do_wr && bus.csr_addr == A_MINSTRETH) begin
            minstret_nxt            = minstret;
            minstret_nxt[63:32]     = wr_val[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle   <= '0;
            minstret <= '0;
        end else begin
            mcycle   <= mcycle_nxt;
            minstret <= minstret_nxt;
        end
    end

    logic unused_ok;
    assign unused_ok = bus.csr_op[2];
`else
    logic unused_ok;
    assign unused_ok = ^{bus.csr_op[2], bus.instret_pulse};
`endif

    assign bus.csr_rdata      = rdata_q;
    assign bus.csr_rvalid     = rvalid_q;
    assign bus.csr_illegal    = illegal_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.busy           = (state != S_IDLE);
endmodule

// File: tb/tb_rip_csr_unit.sv
// Directed self-checking bench for rip_csr_unit (XLEN=32); counter checks follow RIP_CSR_COUNTERS_EN.
module tb_rip_csr_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err    = 0;

    rip_csr_unit_if #(.XLEN(32)) bus ();

    rip_csr_unit #(
        .XLEN        (32),
        .MTVEC_RESET (32'h0000_0207),
        .HART_ID     (32'h0000_0005)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one CSR op for a single accept edge; returns in the result cycle.
    task automatic do_csr(input logic [2:0] op, input logic [11:0] addr, input logic [31:0] wd);
        bus.csr_valid = 1'b1;
        bus.csr_op    = op;
        bus.csr_addr  = addr;
        bus.csr_wdata = wd;
        tick();
        bus.csr_valid = 1'b0;
    endtask

    task automatic chk_rd(input string tag, input logic [31:0] exp_rdata, input logic exp_ill);
        chk({tag, ".rvalid"}, {63'd0, bus.csr_rvalid}, 64'd1);
        chk({tag, ".illegal"}, {63'd0, bus.csr_illegal}, {63'd0, exp_ill});
        chk({tag, ".rdata"}, {32'd0, bus.csr_rdata}, {32'd0, exp_rdata});
    endtask

    initial begin
        bus.csr_valid     = 1'b0;
        bus.csr_op        = 3'b000;
        bus.csr_addr      = 12'h000;
        bus.csr_wdata     = '0;
        bus.trap_req      = 1'b0;
        bus.trap_cause    = '0;
        bus.trap_pc       = '0;
        bus.mret_req      = 1'b0;
        bus.instret_pulse = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst.busy", {63'd0, bus.busy}, 64'd0);
        chk("rst.rvalid", {63'd0, bus.csr_rvalid}, 64'd0);
        chk("rst.illegal", {63'd0, bus.csr_illegal}, 64'd0);
        chk("rst.redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("rst.rdata", {32'd0, bus.csr_rdata}, 64'd0);
        chk("rst.redirect_pc", {32'd0, bus.redirect_pc}, 64'd0);

        do_csr(3'b010, 12'h300, 32'h0);
        chk_rd("rs_mstatus_reset", 32'h0000_1800, 1'b0);
        tick();
        chk("rvalid_pulse", {63'd0, bus.csr_rvalid}, 64'd0);

        do_csr(3'b001, 12'h305, 32'h8000_0103);
        chk_rd("rw_mtvec_old", 32'h0000_0204, 1'b0);
        do_csr(3'b010, 12'h305, 32'h0);
        chk_rd("rs_mtvec", 32'h8000_0100, 1'b0);

        do_csr(3'b001, 12'h340, 32'hDEAD_BEEF);
        chk_rd("rw_mscratch", 32'h0, 1'b0);
        do_csr(3'b011, 12'h340, 32'h0000_FFFF);
        chk_rd("rc_mscratch_old", 32'hDEAD_BEEF, 1'b0);
        do_csr(3'b110, 12'h340, 32'h0000_0003);
        chk_rd("rsi_mscratch_old", 32'hDEAD_0000, 1'b0);
        do_csr(3'b010, 12'h340, 32'h0);
        chk_rd("rs_mscratch", 32'hDEAD_0003, 1'b0);

        do_csr(3'b001, 12'h300, 32'h0000_0008);
        chk_rd("rw_mstatus_mie", 32'h0000_1800, 1'b0);

        // Trap, MRET and a CSR write all offered together: only the trap may run.
        bus.trap_req   = 1'b1;
        bus.trap_cause = 32'h0000_000B;
        bus.trap_pc    = 32'h0000_0107;
        bus.mret_req   = 1'b1;
        bus.csr_valid  = 1'b1;
        bus.csr_op     = 3'b001;
        bus.csr_addr   = 12'h340;
        bus.csr_wdata  = 32'h0000_1234;
        tick();
        bus.trap_req  = 1'b0;
        bus.mret_req  = 1'b0;
        bus.csr_valid = 1'b0;
        chk("trap.n1.busy", {63'd0, bus.busy}, 64'd1);
        chk("trap.n1.redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        chk("trap.n1.rvalid", {63'd0, bus.csr_rvalid}, 64'd0);
        tick();
        chk("trap.n2.busy", {63'd0, bus.busy}, 64'd1);
        chk("trap.n2.redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        chk("trap.n2.redirect_pc", {32'd0, bus.redirect_pc}, 64'h8000_0100);
        tick();
        chk("trap.n3.busy", {63'd0, bus.busy}, 64'd0);
        chk("trap.n3.redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);

        do_csr(3'b010, 12'h341, 32'h0);
        chk_rd("trap.mepc", 32'h0000_0104, 1'b0);
        do_csr(3'b010, 12'h342, 32'h0);
        chk_rd("trap.mcause", 32'h0000_000B, 1'b0);
        do_csr(3'b010, 12'h300, 32'h0);
        chk_rd("trap.mstatus", 32'h0000_1880, 1'b0);
        do_csr(3'b010, 12'h340, 32'h0);
        chk_rd("trap.mscratch_untouched", 32'hDEAD_0003, 1'b0);

        // MRET, with a CSR write offered while busy that must be dropped.
        bus.mret_req = 1'b1;
        tick();
        bus.mret_req  = 1'b0;
        chk("mret.n1.busy", {63'd0, bus.busy}, 64'd1);
        chk("mret.n1.redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        bus.csr_valid = 1'b1;
        bus.csr_op    = 3'b001;
        bus.csr_addr  = 12'h340;
        bus.csr_wdata = 32'h0000_0055;
        tick();
        bus.csr_valid = 1'b0;
        chk("mret.n2.busy", {63'd0, bus.busy}, 64'd1);
        chk("mret.n2.rvalid", {63'd0, bus.csr_rvalid}, 64'd0);
        chk("mret.n2.redirect_valid", {63'd0, bus.redirect_valid}, 64'd1);
        chk("mret.n2.redirect_pc", {32'd0, bus.redirect_pc}, 64'h0000_0104);
        tick();
        chk("mret.n3.busy", {63'd0, bus.busy}, 64'd0);
        chk("mret.n3.redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        do_csr(3'b010, 12'h300, 32'h0);
        chk_rd("mret.mstatus", 32'h0000_1888, 1'b0);
        do_csr(3'b010, 12'h340, 32'h0);
        chk_rd("busy_write_dropped", 32'hDEAD_0003, 1'b0);

        do_csr(3'b001, 12'hF14, 32'h0000_0099);
        chk_rd("rw_mhartid", 32'h0, 1'b1);
        do_csr(3'b010, 12'hF14, 32'h0);
        chk_rd("rs_mhartid", 32'h0000_0005, 1'b0);
        do_csr(3'b011, 12'hF14, 32'h0000_0001);
        chk_rd("rc_mhartid_nz", 32'h0, 1'b1);
        do_csr(3'b001, 12'h7C0, 32'h0000_0001);
        chk_rd("rw_unmapped", 32'h0, 1'b1);

        do_csr(3'b001, 12'h300, 32'hFFFF_FFFF);
        chk_rd("warl_mstatus_old", 32'h0000_1888, 1'b0);
        do_csr(3'b011, 12'h300, 32'h0000_0008);
        chk_rd("warl_mstatus", 32'h0000_1888, 1'b0);
        do_csr(3'b010, 12'h300, 32'h0);
        chk_rd("rc_mstatus_mie", 32'h0000_1880, 1'b0);
        do_csr(3'b001, 12'h341, 32'h0000_0203);
        do_csr(3'b010, 12'h341, 32'h0);
        chk_rd("mepc_align", 32'h0000_0200, 1'b0);

        // Reset while in TRAP_SAVE: no redirect, back to IDLE with reset state.
        bus.trap_req   = 1'b1;
        bus.trap_cause = 32'h0000_0002;
        bus.trap_pc    = 32'h0000_0300;
        tick();
        bus.trap_req = 1'b0;
        chk("rstseq.busy_before", {63'd0, bus.busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstseq.busy", {63'd0, bus.busy}, 64'd0);
        chk("rstseq.redirect_valid", {63'd0, bus.redirect_valid}, 64'd0);
        tick();
        chk("rstseq.redirect_valid2", {63'd0, bus.redirect_valid}, 64'd0);
        do_csr(3'b010, 12'h341, 32'h0);
        chk_rd("rstseq.mepc", 32'h0, 1'b0);
        do_csr(3'b010, 12'h305, 32'h0);
        chk_rd("rstseq.mtvec", 32'h0000_0204, 1'b0);

`ifdef RIP_CSR_COUNTERS_EN
        do_csr(3'b001, 12'hB00, 32'hFFFF_FFFF);
        chk("cnt.rw_mcycle.illegal", {63'd0, bus.csr_illegal}, 64'd0);
        tick();
        do_csr(3'b010, 12'hB80, 32'h0);
        chk_rd("cnt.mcycleh_carry", 32'h0000_0001, 1'b0);
        do_csr(3'b010, 12'hC80, 32'h0);
        chk_rd("cnt.cycleh_shadow", 32'h0000_0001, 1'b0);
        do_csr(3'b001, 12'hC00, 32'h0000_0001);
        chk_rd("cnt.rw_cycle_ro", 32'h0, 1'b1);
        bus.instret_pulse = 1'b1;
        do_csr(3'b001, 12'hB02, 32'h0000_0010);
        tick();
        tick();
        tick();
        bus.instret_pulse = 1'b0;
        do_csr(3'b010, 12'hB02, 32'h0);
        chk_rd("cnt.minstret", 32'h0000_0013, 1'b0);
`else
        do_csr(3'b010, 12'hB00, 32'h0);
        chk_rd("nocnt.rs_mcycle", 32'h0, 1'b1);
        do_csr(3'b001, 12'hB80, 32'hFFFF_FFFF);
        chk_rd("nocnt.rw_mcycleh", 32'h0, 1'b1);
        do_csr(3'b010, 12'hC02, 32'h0);
        chk_rd("nocnt.rs_instret", 32'h0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
